// File: rtl/mux2_arb.sv
// Two-requester arbiter driving a 2:1 mux select, with guard blanking between select change and grant.
// Define MUX2_ARB_PREEMPT_EN to add dwell-limited preemption of a long-holding owner.
module mux2_arb #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic       sel,
  output logic [1:0] grant,
  output logic       blank,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_OWN   = 2'd2
  } state_t;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_guard_range
    $error("mux2_arb: GUARD_CYCLES out of range 1..255");
  end
  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_dwell_range
    $error("mux2_arb: DWELL_CYCLES out of range 1..255");
  end

  state_t     r_state;
  logic       r_sel;
  logic [1:0] r_grant;
  logic       r_blank;
  logic       r_busy;
  logic       r_target;
  logic       r_last;
  logic [7:0] r_gcnt;
  logic       w_tgt;

`ifdef MUX2_ARB_PREEMPT_EN
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);
  logic [7:0] r_dcnt;
`endif

  // On a tie the requester that did not own the path last wins.
  always_comb begin
    w_tgt = 1'b0;
    case (req)
      2'b01:   w_tgt = 1'b0;
      2'b10:   w_tgt = 1'b1;
      default: w_tgt = ~r_last;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_grant  <= '0;
      r_blank  <= 1'b1;
      r_busy   <= 1'b0;
      r_target <= 1'b0;
      r_last   <= 1'b1;
      r_gcnt   <= '0;
`ifdef MUX2_ARB_PREEMPT_EN
      r_dcnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state  <= S_GUARD;
            r_target <= w_tgt;
            r_sel    <= w_tgt;
            r_gcnt   <= GUARD_LOAD;
            r_busy   <= 1'b1;
          end
        end
        S_GUARD: begin
          // Abort has priority over guard expiry so a dropped request never sees a grant pulse.
          if (!req[r_target]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_gcnt  <= '0;
          end else if (r_gcnt == '0) begin
            r_state <= S_OWN;
            r_grant <= r_target ? 2'b10 : 2'b01;
            r_blank <= 1'b0;
            r_last  <= r_target;
`ifdef MUX2_ARB_PREEMPT_EN
            r_dcnt  <= DWELL_LOAD;
`endif
          end else begin
            r_gcnt <= r_gcnt - 8'd1;
          end
        end
        S_OWN: begin
          if (!req[r_target]) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_blank <= 1'b1;
            r_busy  <= 1'b0;
`ifdef MUX2_ARB_PREEMPT_EN
            r_dcnt  <= '0;
          end else if (r_dcnt == '0 && req[!r_target]) begin
            r_state  <= S_GUARD;
            r_target <= !r_target;
            r_sel    <= !r_target;
            r_grant  <= '0;
            r_blank  <= 1'b1;
            r_gcnt   <= GUARD_LOAD;
          end else if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - 8'd1;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_blank <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign blank = r_blank;
  assign busy  = r_busy;

endmodule

// File: tb/tb_mux2_arb.sv
// Directed self-checking bench for mux2_arb (default parameters); follows MUX2_ARB_PREEMPT_EN if defined.
module tb_mux2_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       sel;
  logic [1:0] grant;
  logic       blank;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_errors;

  mux2_arb #(.GUARD_CYCLES(4), .DWELL_CYCLES(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .sel   (sel),
    .grant (grant),
    .blank (blank),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {sel, grant, blank, busy} against the hand-computed values.
  task automatic chk(input string tag, input logic e_sel, input logic [1:0] e_grant,
                     input logic e_blank, input logic e_busy);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {sel, grant, blank, busy};
    exp = {e_sel, e_grant, e_blank, e_busy};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed {sel,grant,blank,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    tick();
    chk("reset", 1'b0, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 1'b0, 2'b00, 1'b1, 1'b0);

    // Single requester 0: sel at cycle 1, blanked 1-4, grant at 5.
    req = 2'b01;
    tick();
    chk("r0_guard_c1", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("r0_guard_c4", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    chk("r0_grant_c5", 1'b0, 2'b01, 1'b0, 1'b1);

    // Requester 1 joins; owner 0 keeps the path until it drops.
    req = 2'b11;
    tick();
    tick();
    chk("r0_hold_tie", 1'b0, 2'b01, 1'b0, 1'b1);
    req = 2'b10;
    tick();
    chk("r0_release_idle", 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    chk("r1_guard_entry", 1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("r1_guard_c4", 1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    chk("r1_grant", 1'b1, 2'b10, 1'b0, 1'b1);

    req = 2'b00;
    tick();
    chk("r1_release", 1'b1, 2'b00, 1'b1, 1'b0);
    tick();
    chk("idle_sel_hold", 1'b1, 2'b00, 1'b1, 1'b0);

    // Short req1 pulse aborts the guard; no grant, sel stays 1.
    req = 2'b10;
    tick();
    chk("abort_guard_c1", 1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    chk("abort_guard_c2", 1'b1, 2'b00, 1'b1, 1'b1);
    req = 2'b00;
    tick();
    chk("abort_idle", 1'b1, 2'b00, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk("abort_no_grant", 1'b1, 2'b00, 1'b1, 1'b0);

    // Tie after requester 1 last owned: requester 0 wins.
    req = 2'b11;
    tick();
    chk("rr_guard_sel0", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    tick();
    chk("rr_grant0", 1'b0, 2'b01, 1'b0, 1'b1);

`ifdef MUX2_ARB_PREEMPT_EN
    // Owner 0 has owned 1 cycle; preemption expected at owned cycle 16.
    n = 1;
    while (grant == 2'b01 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    assert (n == 17) else begin
      n_errors++;
      $error("FAIL preempt_time observed=%0d expected=17", n);
    end
    chk("preempt_edge", 1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("preempt_guard_c4", 1'b1, 2'b00, 1'b1, 1'b1);
    tick();
    chk("preempt_grant1", 1'b1, 2'b10, 1'b0, 1'b1);
`else
    for (int i = 0; i < 30; i++) tick();
    chk("no_preempt_hold", 1'b0, 2'b01, 1'b0, 1'b1);
`endif

    // Reset while owning drops grant immediately; requester 0 wins the next tie.
    rst_n = 1'b0;
    tick();
    chk("reset_in_own", 1'b0, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_guard", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("post_reset_guard_c4", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    chk("post_reset_grant0", 1'b0, 2'b01, 1'b0, 1'b1);

    req = 2'b00;
    tick();
    chk("final_release", 1'b0, 2'b00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
